// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage: FSM state encoding,
// the 16-bit data word, and the hex 7-segment patterns (a at bit 7, dp at bit 0).
package simple_pkg;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    typedef logic [15:0] word_t;

    localparam word_t TIMEOUT_DATA = 16'hFFFF;

    // Indexed by nibble value; the first element of the concatenation is nibble F.
    localparam logic [15:0][7:0] SEG7_PAT = {
        8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
        8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
    };

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response port seen by the memory stage.
interface mem_stage_if;
    import simple_pkg::*;

    word_t memAddr;
    word_t memWdata;
    logic  memRe;
    logic  memWe;
    word_t memRdata;
    logic  memAck;

    modport master (output memAddr, memWdata, memRe, memWe, input memRdata, memAck);
    modport slave  (input memAddr, memWdata, memRe, memWe, output memRdata, memAck);
endinterface

// File: rtl/mem_stage_seg7.sv
// Hex nibble to 7-segment pattern (a at bit 7, dp at bit 0, dp always off).
module seg7_encode
    import simple_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);
    assign seg = SEG7_PAT[nibble];
endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: ALU pass-through, loads and stores with ack timeout.
// Optional MEM_LED_EN shows the last loaded word on signal1..4 as hex digits.
module mem_stage
    import simple_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             validIn,
    input  word_t            aluResult,
    input  logic             writeRegIn,
    input  logic [2:0]       regAddrIn,
    input  word_t            addrIn,
    input  word_t            storeDataIn,
    input  logic             readEnable,
    input  logic             writeEnable,
    mem_stage_if.master      mem,
    output logic             stall,
    output logic             validOut,
    output word_t            writeData,
    output logic             writeRegOut,
    output logic [2:0]       regAddrOut,
    output logic             timeoutErr,
    output logic             protoErr,
    output logic [7:0]       signal1,
    output logic [7:0]       signal2,
    output logic [7:0]       signal3,
    output logic [7:0]       signal4
);

    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;
    word_t      lat_alu;
    logic       lat_wr;
    logic [2:0] lat_reg;
    logic       timeout_hit;
    logic       mem_req;

    // The cycle in which the counter would reach ACK_TIMEOUT is the last wait cycle.
    assign timeout_hit = (cnt == TMO_LAST);
    assign mem_req     = readEnable ^ writeEnable;

    always_comb begin
        stall = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE:        stall = validIn && mem_req;
                READ, WRITE: stall = !(mem.memAck || timeout_hit);
                default:     stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            lat_alu      <= '0;
            lat_wr       <= 1'b0;
            lat_reg      <= 3'd0;
            mem.memAddr  <= '0;
            mem.memWdata <= '0;
            mem.memRe    <= 1'b0;
            mem.memWe    <= 1'b0;
            validOut     <= 1'b0;
            writeData    <= '0;
            writeRegOut  <= 1'b0;
            regAddrOut   <= 3'd0;
            timeoutErr   <= 1'b0;
            protoErr     <= 1'b0;
        end else begin
            validOut <= 1'b0;
            case (state)
                IDLE: begin
                    if (validIn) begin
                        if (mem_req) begin
                            lat_alu     <= aluResult;
                            lat_wr      <= writeRegIn;
                            lat_reg     <= regAddrIn;
                            mem.memAddr <= addrIn;
                            if (writeEnable)
                                mem.memWdata <= storeDataIn;
                            mem.memRe   <= readEnable;
                            mem.memWe   <= writeEnable;
                            cnt         <= 8'd0;
                            state       <= readEnable ? READ : WRITE;
                        end else begin
                            // Conflicting enables degrade to a plain pass-through.
                            if (readEnable && writeEnable)
                                protoErr <= 1'b1;
                            validOut    <= 1'b1;
                            writeData   <= aluResult;
                            writeRegOut <= writeRegIn;
                            regAddrOut  <= regAddrIn;
                        end
                    end
                end
                READ, WRITE: begin
                    if (mem.memAck) begin
                        validOut    <= 1'b1;
                        writeData   <= (state == READ) ? mem.memRdata : lat_alu;
                        writeRegOut <= lat_wr;
                        regAddrOut  <= lat_reg;
                        mem.memRe   <= 1'b0;
                        mem.memWe   <= 1'b0;
                        state       <= IDLE;
                    end else if (timeout_hit) begin
                        timeoutErr  <= 1'b1;
                        validOut    <= 1'b1;
                        writeData   <= TIMEOUT_DATA;
                        writeRegOut <= 1'b0;
                        regAddrOut  <= lat_reg;
                        mem.memRe   <= 1'b0;
                        mem.memWe   <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_LED_EN
    logic [3:0][7:0] seg_next;
    logic [3:0][7:0] seg_q;

    for (genvar gi = 0; gi < 4; gi++) begin : g_seg
        seg7_encode u_seg (
            .nibble (mem.memRdata[gi*4 +: 4]),
            .seg    (seg_next[gi])
        );
    end

    // Patterns are registered (not the word) so reset shows blank digits.
    always_ff @(posedge clk) begin
        if (!rst_n)
            seg_q <= '0;
        else if (state == READ && mem.memAck)
            seg_q <= seg_next;
    end

    assign signal1 = seg_q[3];
    assign signal2 = seg_q[2];
    assign signal3 = seg_q[1];
    assign signal4 = seg_q[0];
`else
    assign signal1 = 8'h00;
    assign signal2 = 8'h00;
    assign signal3 = 8'h00;
    assign signal4 = 8'h00;
`endif

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15: maximum cycles spent waiting for memAck per access (range 1..255).
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 validIn  in  1  upstream execute-stage bundle is valid this cycle.
REQ-005 aluResult  in  16  execute-stage ALU result.
REQ-006 writeRegIn  in  1  register write-back request.
REQ-007 regAddrIn  in  3  destination register.
REQ-008 addrIn  in  16  data-memory address.
REQ-009 storeDataIn  in  16  store data.
REQ-010 readEnable / writeEnable  in  1 each  load / store request.
REQ-011 memAddr  out  16;  memWdata  out  16;  memRe  out  1;  memWe  out  1  memory request port.
REQ-012 memRdata  in  16;  memAck  in  1  memory response; memAck marks the access complete.
REQ-013 stall  out  1  combinational; upstream holds its bundle while high.
REQ-014 validOut  out  1;  writeData  out  16;  writeRegOut  out  1;  regAddrOut  out  3  write-back bundle.
REQ-015 timeoutErr  out  1;  protoErr  out  1  sticky error flags.
REQ-016 signal1..signal4  out  8 each  7-segment hex display of last loaded word (see REQ-033).

Function
REQ-017 FSM states: IDLE, READ, WRITE; inputs are sampled only in IDLE.
REQ-018 IDLE, validIn, neither enable set: next cycle validOut=1, writeData=aluResult, writeRegOut/regAddrOut registered from inputs; latency 1; stall=0.
REQ-019 IDLE, validIn, readEnable only: latch the bundle; next cycle memRe=1, memAddr=addrIn; enter READ; stall=1 in the accept cycle.
REQ-020 IDLE, validIn, writeEnable only: latch the bundle; next cycle memWe=1, memAddr=addrIn, memWdata=storeDataIn; enter WRITE; stall=1 in the accept cycle.
REQ-021 IDLE, validIn, both enables set: set protoErr; treat as REQ-018 pass-through with no memory access.
REQ-022 READ/WRITE: hold memRe/memWe, memAddr and memWdata stable until completion; stall=1 until the completion cycle, then 0 in that cycle.
REQ-023 memAck is ignored in IDLE; an ack in the first READ/WRITE cycle is legal, giving minimum load/store latency 2 cycles from accept to validOut.
REQ-024 READ + memAck: next cycle validOut=1, writeData=memRdata, latched writeReg/regAddr; memRe=0; return to IDLE.
REQ-025 WRITE + memAck: next cycle validOut=1, writeData=latched aluResult, latched writeReg/regAddr; memWe=0; return to IDLE.
REQ-026 Wait counter (8 bit) clears on entry to READ/WRITE and increments each non-ack cycle.
REQ-027 Counter reaching ACK_TIMEOUT without ack: set timeoutErr; next cycle validOut=1, writeRegOut=0, writeData=16'hFFFF; drop request; return to IDLE.
REQ-028 memAck in the same cycle as the timeout condition counts as success.
REQ-029 validOut is a single-cycle pulse per accepted bundle; it is 0 in every other cycle.
REQ-030 Error flags stay set until reset.

Reset
REQ-031 rst_n low at a clock edge: state=IDLE; counter=0; memRe=memWe=0; memAddr=memWdata=0; validOut=writeRegOut=0; writeData=0; regAddrOut=0; timeoutErr=protoErr=0; signal1..4=8'h00.
REQ-032 Reset mid-access abandons the access with no validOut pulse; stall=0 while rst_n is low.

Configuration
REQ-033 Macro MEM_LED_EN defined: each completed load encodes memRdata nibbles [15:12],[11:8],[7:4],[3:0] onto signal1..4 as hex 7-segment, segment a at bit 7, dp at bit 0 and always 0. Patterns: 0=FC, 1=60, 8=FE, F=8E. Undefined: signal1..4 are constant 8'h00.

Structure
REQ-034 Package simple_pkg holds the FSM state enum, the 16-bit word typedef and the 7-segment pattern constants.
REQ-035 One sub-module, seg7_encode (4-bit in, 8-bit out), instantiated four times only under MEM_LED_EN.

Verification
REQ-036 ALU op aluResult=16'h1234, writeRegIn=1, regAddrIn=5 -> next cycle validOut=1, writeData=1234, regAddrOut=5, stall=0 throughout.
REQ-037 Load addrIn=16'h0040, memAck on the 3rd READ cycle with memRdata=16'hBEEF -> memRe=1 for 3 cycles, stall=1 for 3 cycles, then writeData=BEEF. With MEM_LED_EN, signal1..4 = 3E,9E,9E,8E.
REQ-038 Store addrIn=16'h0010, storeDataIn=16'h00AA, ack on the first cycle -> memWe=1 for 1 cycle with memWdata=00AA; validOut 2 cycles after accept.
REQ-039 Load, no ack, ACK_TIMEOUT=4 -> timeoutErr=1 after 4 wait cycles; validOut with writeRegOut=0, writeData=FFFF; next bundle accepted.
REQ-040 readEnable=writeEnable=1 -> protoErr=1, no memRe/memWe, pass-through result.
REQ-041 rst_n low during READ -> memRe=0, stall=0, no validOut, state IDLE.
